// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and width/pointer helpers for the FIFO family.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UDF  = 2'd2
    } fifo_err_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap by compare so non-power-of-2 depths work.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port register array, combinational read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/ring_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ring_fifo
// Description : Circular-buffer FIFO with count, thresholds and error pulses.
//               Define RING_FIFO_FWFT_EN for first-word-fall-through output.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
    parameter int CNT    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             a_full,
    output logic             empty,
    output logic             a_empty,
    output logic [CNT-1:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             PW       = ptr_w(DEPTH);
    localparam logic [CNT-1:0] c_depth  = CNT'(DEPTH);
    localparam logic [CNT-1:0] c_af_lvl = CNT'(AF_LVL);
    localparam logic [CNT-1:0] c_ae_lvl = CNT'(AE_LVL);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [PW-1:0]    w_raddr;
    logic [CNT-1:0]   r_count;
    logic [CNT-1:0]   w_count_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic [WIDTH-1:0] w_rdata;
    logic             w_dout_ld;
    logic             w_pop_ok;
    logic             w_push_ok;
    fifo_err_e        r_err;
    fifo_err_e        w_err_nxt;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign a_full  = (r_count >= c_af_lvl);
    assign a_empty = (r_count <= c_ae_lvl);
    assign count   = r_count;
    assign dout    = r_dout;

    assign overflow  = (r_err == ERR_OVF);
    assign underflow = (r_err == ERR_UDF);

    assign w_pop_ok     = pop & ~empty;
    assign w_push_ok    = push & (~full | w_pop_ok);
    assign w_wr_ptr_nxt = PW'(ptr_next(int'(r_wr_ptr), DEPTH));
    assign w_rd_ptr_nxt = PW'(ptr_next(int'(r_rd_ptr), DEPTH));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CNT'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - CNT'(1);
        end

        w_err_nxt = ERR_NONE;
        if (push && !w_push_ok) begin
            w_err_nxt = ERR_OVF;
        end else if (pop && !w_pop_ok) begin
            w_err_nxt = ERR_UDF;
        end
    end

`ifdef RING_FIFO_FWFT_EN
    // Preload whatever will be the head after this edge; if that slot is being
    // written now the array does not have it yet, so take it from din.
    assign w_raddr    = w_pop_ok ? w_rd_ptr_nxt : r_rd_ptr;
    assign w_dout_ld  = (w_count_nxt != '0);
    assign w_dout_nxt = (w_push_ok && (w_raddr == r_wr_ptr)) ? din : w_rdata;
`else
    assign w_raddr    = r_rd_ptr;
    assign w_dout_ld  = w_pop_ok;
    assign w_dout_nxt = w_rdata;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_err    <= ERR_NONE;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_dout_ld) begin
                r_dout <= w_dout_nxt;
            end
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push_ok),
        .waddr (r_wr_ptr),
        .wdata (din),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_fifo
// Description : Self-checking bench for ring_fifo against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 32;
    localparam int AF_LVL = 28;
    localparam int AE_LVL = 3;
    localparam int CNT    = $clog2(DEPTH + 1);
`ifdef RING_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic             clk  = 1'b0;
    logic             rstn = 1'b1;
    logic             push = 1'b0;
    logic             pop  = 1'b0;
    logic [WIDTH-1:0] din  = '0;
    logic [WIDTH-1:0] dout;
    logic             full, a_full, empty, a_empty, overflow, underflow;
    logic [CNT-1:0]   count;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    bit               exp_ovf  = 1'b0;
    bit               exp_udf  = 1'b0;
    bit               cmp_en   = 1'b0;
    int               n_vec    = 0;
    int               n_mis    = 0;

    ring_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .din       (din),
        .pop       (pop),
        .dout      (dout),
        .full      (full),
        .a_full    (a_full),
        .empty     (empty),
        .a_empty   (a_empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // Queue-level view of one clock edge.
    task automatic model_step(input bit p, input bit r, input logic [WIDTH-1:0] d);
        bit               pok;
        bit               wok;
        logic [WIDTH-1:0] h;
        pok = r && (q.size() > 0);
        wok = p && ((q.size() < DEPTH) || pok);
        exp_ovf = p && !wok;
        exp_udf = r && !pok;
        if (pok) begin
            h = q.pop_front();
            if (!FWFT) exp_dout = h;
        end
        if (wok) q.push_back(d);
        if (FWFT && (q.size() > 0)) exp_dout = q[0];
    endtask

    task automatic cyc(input bit p, input bit r, input logic [WIDTH-1:0] d);
        push = p;
        pop  = r;
        din  = d;
        @(posedge clk);
        model_step(p, r, d);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count",     32'(count),     32'(q.size()));
            chk("full",      32'(full),      32'(q.size() == DEPTH));
            chk("empty",     32'(empty),     32'(q.size() == 0));
            chk("a_full",    32'(a_full),    32'(q.size() >= AF_LVL));
            chk("a_empty",   32'(a_empty),   32'(q.size() <= AE_LVL));
            chk("dout",      32'(dout),      32'(exp_dout));
            chk("overflow",  32'(overflow),  32'(exp_ovf));
            chk("underflow", 32'(underflow), 32'(exp_udf));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pp;
        int rp;
        #1 rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout",  32'(dout),  32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        cmp_en = 1'b1;

        // Fill 0x01..0x20, overflow, drain with threshold pins.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, WIDTH'(i + 1));
            if (i == 0) chk("first_push_dout", 32'(dout), FWFT ? 32'h01 : 32'h00);
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd32);
        cyc(1'b1, 1'b0, 8'hEE);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd32);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_dout", 32'(dout), FWFT ? ((i < DEPTH - 1) ? 32'(i + 2) : 32'h20) : 32'(i + 1));
            if (31 - i == 28) chk("a_full_at_28", 32'(a_full), 32'd1);
            if (31 - i == 27) chk("a_full_at_27", 32'(a_full), 32'd0);
            if (31 - i == 4)  chk("a_empty_at_4", 32'(a_empty), 32'd0);
            if (31 - i == 3)  chk("a_empty_at_3", 32'(a_empty), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Errors at empty.
        cyc(1'b0, 1'b1, 8'h00);
        chk("udf_pulse", 32'(underflow), 32'd1);
        chk("udf_dout",  32'(dout),      32'h20);
        cyc(1'b1, 1'b1, 8'h55);
        chk("pp_empty_count", 32'(count),     32'd1);
        chk("pp_empty_udf",   32'(underflow), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("pp_empty_dout",  32'(dout),      32'h55);

        // Wrap.
        repeat (2) begin
            repeat (20) cyc(1'b1, 1'b0, WIDTH'($urandom));
            repeat (20) cyc(1'b0, 1'b1, 8'h00);
        end
        chk("wrap_count", 32'(count), 32'd0);

        // Simultaneous at count 5 and at full.
        repeat (5) cyc(1'b1, 1'b0, WIDTH'($urandom));
        repeat (10) cyc(1'b1, 1'b1, WIDTH'($urandom));
        chk("sim5_count", 32'(count), 32'd5);
        repeat (5) cyc(1'b0, 1'b1, 8'h00);
        repeat (DEPTH) cyc(1'b1, 1'b0, WIDTH'($urandom));
        repeat (10) cyc(1'b1, 1'b1, WIDTH'($urandom));
        chk("sim32_count", 32'(count),    32'd32);
        chk("sim32_ovf",   32'(overflow), 32'd0);
        repeat (DEPTH) cyc(1'b0, 1'b1, 8'h00);

        // Asynchronous reset mid-stream at count 17.
        repeat (17) cyc(1'b1, 1'b0, WIDTH'($urandom));
        push = 1'b0;
        pop  = 1'b0;
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_dout",  32'(dout),  32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_pop", 32'(dout), 32'hAA);

        // Randomized phases with varying push/pop bias.
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin pp = 70; rp = 30; end
                1: begin pp = 30; rp = 70; end
                2: begin pp = 50; rp = 50; end
                3: begin pp = 90; rp = 90; end
                4: begin pp = 95; rp = 10; end
                default: begin pp = 10; rp = 95; end
            endcase
            repeat (500) begin
                cyc($urandom_range(0, 99) < pp, $urandom_range(0, 99) < rp, WIDTH'($urandom));
            end
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
